mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported memory between instruction fetch (IM side) and the load/store
//   stage (DM side, driven by the MemRead/MemWrite decode).
// - Registered FSM issues one transaction at a time on the memory port, with a req/ack handshake.
// - Returns data to the requester as a one-cycle ready pulse.
// - Raises per-stage stall lines so the pipeline holds while a request is outstanding.
// PARAMETERS
// - ADDR_W    32  address width, both sides and the memory port
// - DATA_W    32  data width
// - MAX_WAIT  16  cycles allowed from mem_req rising to mem_ack before timeout abort (>=2)
// PORTS
// - clk        in   1       single clock, all state on rising edge
// - rst        in   1       synchronous, active-high reset
// - im_req     in   1       fetch request, held until im_ready
// - im_addr    in   ADDR_W  fetch address, stable while im_req
// - im_rdata   out  DATA_W  fetch data, valid when im_ready
// - im_ready   out  1       one-cycle completion pulse for fetch
// - dm_req     in   1       load/store request, held until dm_ready
// - dm_we      in   4       byte write strobes; 0 = load
// - dm_addr    in   ADDR_W  load/store address
// - dm_wdata   in   DATA_W  store data
// - dm_rdata   out  DATA_W  load data, valid when dm_ready; 0 for stores
// - dm_ready   out  1       one-cycle completion pulse for load/store
// - mem_req    out  1       memory request, registered, held until mem_ack or abort
// - mem_we     out  4       registered copy of granted strobes (0 for fetch)
// - mem_addr   out  ADDR_W  registered granted address
// - mem_wdata  out  DATA_W  registered granted write data
// - mem_ack    in   1       memory completion, one cycle; ignored unless mem_req=1
// - mem_rdata  in   DATA_W  memory read data, valid with mem_ack
// - stall_if   out  1       comb: im_req & ~im_ready
// - stall_mem  out  1       comb: dm_req & ~dm_ready
// - err        out  1       one-cycle pulse on timeout abort
// BEHAVIOUR
// - Reset: FSM=IDLE; mem_req, mem_we, mem_addr, mem_wdata, im_*/dm_* rdata and ready, err,
//   wait counter all 0.
// - States:
//   - IDLE: an eligible request wins; load mem_* regs; go GNT_I or GNT_D.
//   - GNT_I / GNT_D: mem_req=1; count cycles.
//   - On mem_ack: capture mem_rdata into the granted side's rdata; pulse that side's ready
//     next cycle; return to IDLE.
// - Eligible request: req=1 and that side's ready is not 1 this cycle. This blocks re-grant
//   of a completed request still held high.
// - Priority: DM beats IM when both are eligible in IDLE (older instruction first).
// - Latency: req seen in IDLE at cycle N -> mem_req=1 at N+1. Ack at cycle M -> ready=1 at M+1,
//   FSM in IDLE at M+1. New grant at the earliest M+2 for the other side; no bubble beyond that.
// - mem_req drops in the cycle after ack. mem_addr/we/wdata are stable for the whole grant.
// - Fetch grant: mem_we=0 regardless of inputs.
// - Store completion: dm_rdata=0.
// - ready and err are single-cycle pulses; rdata holds its value until the next completion
//   on that side.
// - Timeout: wait counter reaches MAX_WAIT with no ack -> clear mem_req, pulse err together
//   with the granted side's ready (rdata=0), return to IDLE. An ack arriving in the same
//   cycle as the limit wins: normal completion, no err.
// - Requester dropping req mid-grant is illegal (assertion). The transaction still completes
//   and the ready pulse is still emitted.
// - rst mid-grant: everything cleared at the next edge, no ready pulse, no err.
//   A late mem_ack is ignored.
// CONFIGURATION
// - ROUND_ROBIN_EN defined: when both sides are eligible in IDLE, the side NOT granted last
//   wins. The last-granted flag resets to IM, so DM wins the first tie. Timeout aborts update
//   the flag.
// - ROUND_ROBIN_EN undefined: fixed DM-over-IM priority; no last-granted register.
// TESTING
// - Fetch only: im_req=1 at cycle 0, addr=0x100, mem_ack at cycle 3 with rdata=0xDEADBEEF
//   -> mem_req cycles 1-3, im_ready=1 and im_rdata=0xDEADBEEF at cycle 4.
// - Simultaneous: im_req and dm_req (load 0x200) at cycle 0, ack 1 cycle after each req
//   -> DM granted first; dm_ready at cycle 3; IM mem_req at cycle 4; im_ready at cycle 6.
//   Check stall_if is high throughout.
// - Store: dm_we=4'b0011, addr=0x40, wdata=0x1234 -> mem_we=4'b0011 held until ack;
//   dm_ready pulse; dm_rdata=0.
// - Timeout: dm_req with no mem_ack -> mem_req drops after MAX_WAIT=16 cycles;
//   err=1 and dm_ready=1 in the same cycle; dm_rdata=0. Also ack exactly on cycle 16 -> no err.
// - Reset mid-grant: assert rst at cycle 2 of a grant -> all outputs 0 next edge, no ready.
//   A late ack is ignored.
// - ROUND_ROBIN_EN: both requesting continuously -> grants alternate D,I,D,I;
//   without the macro, D repeats whenever dm_req is eligible.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch request side, load/store request side,
// single-ported memory side and the per-stage stall/error lines.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_rdata;
  logic              im_ready;

  logic              dm_req;
  logic [3:0]        dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_req;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;
  logic              err;

  // The arbiter serves requesters and drives the memory port.
  modport slave (
    input  im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    output im_rdata, im_ready, dm_rdata, dm_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, err
  );

  // Environment side: pipeline stages plus the memory model.
  modport master (
    output im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    input  im_rdata, im_ready, dm_rdata, dm_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (IM) and load/store (DM), one transaction at a time.
// Define ROUND_ROBIN_EN to alternate grants on ties; otherwise DM always beats IM.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_req_q;
  logic [3:0]        mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] im_rdata_q;
  logic              im_ready_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              dm_ready_q;
  logic              err_q;
`ifdef ROUND_ROBIN_EN
  logic              last_dm_q;
`endif

  logic im_elig_s;
  logic dm_elig_s;
  logic pick_dm_s;

  // A side whose ready pulse is high this cycle is not eligible, so a held request is not re-granted.
  always_comb begin
    im_elig_s = bus.im_req & ~im_ready_q;
    dm_elig_s = bus.dm_req & ~dm_ready_q;
`ifdef ROUND_ROBIN_EN
    if (im_elig_s && dm_elig_s) begin
      pick_dm_s = ~last_dm_q;
    end else begin
      pick_dm_s = dm_elig_s;
    end
`else
    pick_dm_s = dm_elig_s;
`endif
  end

  // Grant FSM with wait counter; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      im_rdata_q  <= {DATA_W{1'b0}};
      im_ready_q  <= 1'b0;
      dm_rdata_q  <= {DATA_W{1'b0}};
      dm_ready_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_dm_q   <= 1'b0;
`endif
    end else begin
      im_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (im_elig_s || dm_elig_s) begin
            mem_req_q <= 1'b1;
            cnt_q     <= {{(CNT_W-1){1'b0}}, 1'b1};
            if (pick_dm_s) begin
              mem_we_q    <= bus.dm_we;
              mem_addr_q  <= bus.dm_addr;
              mem_wdata_q <= bus.dm_wdata;
              state_q     <= GNT_D;
`ifdef ROUND_ROBIN_EN
              last_dm_q   <= 1'b1;
`endif
            end else begin
              mem_we_q    <= 4'b0000;
              mem_addr_q  <= bus.im_addr;
              mem_wdata_q <= {DATA_W{1'b0}};
              state_q     <= GNT_I;
`ifdef ROUND_ROBIN_EN
              last_dm_q   <= 1'b0;
`endif
            end
          end else begin
            cnt_q <= {CNT_W{1'b0}};
          end
        end
        GNT_I, GNT_D: begin
          // An ack in the same cycle the limit is reached still completes normally.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            state_q   <= IDLE;
            if (state_q == GNT_D) begin
              dm_ready_q <= 1'b1;
              dm_rdata_q <= (mem_we_q == 4'b0000) ? bus.mem_rdata : {DATA_W{1'b0}};
            end else begin
              im_ready_q <= 1'b1;
              im_rdata_q <= bus.mem_rdata;
            end
          end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
            mem_req_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            state_q   <= IDLE;
            err_q     <= 1'b1;
            if (state_q == GNT_D) begin
              dm_ready_q <= 1'b1;
              dm_rdata_q <= {DATA_W{1'b0}};
            end else begin
              im_ready_q <= 1'b1;
              im_rdata_q <= {DATA_W{1'b0}};
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          cnt_q     <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.im_rdata  = im_rdata_q;
  assign bus.im_ready  = im_ready_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.err       = err_q;
  assign bus.stall_if  = bus.im_req & ~im_ready_q;
  assign bus.stall_mem = bus.dm_req & ~dm_ready_q;

  // Requesters must hold their request until the grant completes.
  im_held_a: assert property (@(posedge clk) disable iff (rst) (state_q == GNT_I) |-> bus.im_req);
  dm_held_a: assert property (@(posedge clk) disable iff (rst) (state_q == GNT_D) |-> bus.dm_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, tie priority, store, timeout, ack-at-limit,
// reset mid-grant and back-to-back tie arbitration, all with hand-computed expectations.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle; inputs are driven and outputs sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.im_req    = 1'b0;
    bus.im_addr   = 32'h0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 4'b0000;
    bus.dm_addr   = 32'h0;
    bus.dm_wdata  = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;

    repeat (3) tick();
    check("rst_mem_req",   {31'h0, bus.mem_req},  32'h0);
    check("rst_mem_we",    {28'h0, bus.mem_we},   32'h0);
    check("rst_mem_addr",  bus.mem_addr,          32'h0);
    check("rst_mem_wdata", bus.mem_wdata,         32'h0);
    check("rst_im_ready",  {31'h0, bus.im_ready}, 32'h0);
    check("rst_dm_ready",  {31'h0, bus.dm_ready}, 32'h0);
    check("rst_im_rdata",  bus.im_rdata,          32'h0);
    check("rst_dm_rdata",  bus.dm_rdata,          32'h0);
    check("rst_err",       {31'h0, bus.err},      32'h0);
    rst = 1'b0;

    // Fetch only: req at cycle 0, ack at cycle 3, ready at cycle 4.
    tick();
    bus.im_req  = 1'b1;
    bus.im_addr = 32'h0000_0100;
    #1;
    check("f_stall_if_c0", {31'h0, bus.stall_if}, 32'h1);
    tick();
    check("f_mem_req_c1",  {31'h0, bus.mem_req}, 32'h1);
    check("f_mem_addr_c1", bus.mem_addr,         32'h0000_0100);
    check("f_mem_we_c1",   {28'h0, bus.mem_we},  32'h0);
    tick();
    check("f_mem_req_c2",  {31'h0, bus.mem_req}, 32'h1);
    tick();
    check("f_mem_req_c3",  {31'h0, bus.mem_req}, 32'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("f_im_ready_c4", {31'h0, bus.im_ready}, 32'h1);
    check("f_im_rdata_c4", bus.im_rdata,          32'hDEAD_BEEF);
    check("f_mem_req_c4",  {31'h0, bus.mem_req},  32'h0);
    check("f_stall_if_c4", {31'h0, bus.stall_if}, 32'h0);
    bus.mem_ack = 1'b0;
    bus.im_req  = 1'b0;
    tick();
    check("f_im_ready_c5", {31'h0, bus.im_ready}, 32'h0);
    check("f_im_rdata_c5", bus.im_rdata,          32'hDEAD_BEEF);
    check("f_mem_req_c5",  {31'h0, bus.mem_req},  32'h0);

    // Simultaneous fetch and load: DM first, IM granted right after dm_ready.
    tick();
    bus.im_req  = 1'b1;
    bus.im_addr = 32'h0000_0104;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 4'b0000;
    bus.dm_addr = 32'h0000_0200;
    #1;
    check("s_stall_if_c0",  {31'h0, bus.stall_if},  32'h1);
    check("s_stall_mem_c0", {31'h0, bus.stall_mem}, 32'h1);
    tick();
    check("s_mem_req_c1",  {31'h0, bus.mem_req},  32'h1);
    check("s_mem_addr_c1", bus.mem_addr,          32'h0000_0200);
    check("s_stall_if_c1", {31'h0, bus.stall_if}, 32'h1);
    tick();
    check("s_stall_if_c2", {31'h0, bus.stall_if}, 32'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_AAAA;
    tick();
    check("s_dm_ready_c3", {31'h0, bus.dm_ready}, 32'h1);
    check("s_dm_rdata_c3", bus.dm_rdata,          32'h0000_AAAA);
    check("s_mem_req_c3",  {31'h0, bus.mem_req},  32'h0);
    check("s_stall_if_c3", {31'h0, bus.stall_if}, 32'h1);
    bus.mem_ack = 1'b0;
    bus.dm_req  = 1'b0;
    tick();
    check("s_mem_req_c4",  {31'h0, bus.mem_req},  32'h1);
    check("s_mem_addr_c4", bus.mem_addr,          32'h0000_0104);
    check("s_dm_ready_c4", {31'h0, bus.dm_ready}, 32'h0);
    check("s_stall_if_c4", {31'h0, bus.stall_if}, 32'h1);
    tick();
    check("s_im_ready_c5", {31'h0, bus.im_ready}, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_5555;
    tick();
    check("s_im_ready_c6", {31'h0, bus.im_ready}, 32'h1);
    check("s_im_rdata_c6", bus.im_rdata,          32'h0000_5555);
    bus.mem_ack = 1'b0;
    bus.im_req  = 1'b0;

    // Store: strobes held through the grant, dm_rdata cleared on completion.
    tick();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 4'b0011;
    bus.dm_addr  = 32'h0000_0040;
    bus.dm_wdata = 32'h0000_1234;
    tick();
    check("st_mem_we_c1",    {28'h0, bus.mem_we}, 32'h3);
    check("st_mem_addr_c1",  bus.mem_addr,        32'h0000_0040);
    check("st_mem_wdata_c1", bus.mem_wdata,       32'h0000_1234);
    tick();
    check("st_mem_we_c2",  {28'h0, bus.mem_we},  32'h3);
    check("st_mem_req_c2", {31'h0, bus.mem_req}, 32'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    check("st_dm_ready_c3", {31'h0, bus.dm_ready}, 32'h1);
    check("st_dm_rdata_c3", bus.dm_rdata,          32'h0);
    bus.mem_ack = 1'b0;
    bus.dm_req  = 1'b0;
    bus.dm_we   = 4'b0000;

    // Ack exactly on the 16th request cycle: normal completion, no err.
    tick();
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_0084;
    tick();
    check("a16_mem_req_c1", {31'h0, bus.mem_req}, 32'h1);
    repeat (15) tick();
    check("a16_mem_req_c16", {31'h0, bus.mem_req}, 32'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0077;
    tick();
    check("a16_dm_ready_c17", {31'h0, bus.dm_ready}, 32'h1);
    check("a16_err_c17",      {31'h0, bus.err},      32'h0);
    check("a16_dm_rdata_c17", bus.dm_rdata,          32'h0000_0077);
    check("a16_mem_req_c17",  {31'h0, bus.mem_req},  32'h0);
    bus.mem_ack = 1'b0;
    bus.dm_req  = 1'b0;

    // Timeout: no ack, abort after 16 request cycles with err and dm_ready together.
    tick();
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_0080;
    tick();
    check("to_mem_req_c1", {31'h0, bus.mem_req}, 32'h1);
    repeat (15) tick();
    check("to_mem_req_c16", {31'h0, bus.mem_req}, 32'h1);
    check("to_err_c16",     {31'h0, bus.err},     32'h0);
    tick();
    check("to_mem_req_c17",  {31'h0, bus.mem_req},  32'h0);
    check("to_err_c17",      {31'h0, bus.err},      32'h1);
    check("to_dm_ready_c17", {31'h0, bus.dm_ready}, 32'h1);
    check("to_dm_rdata_c17", bus.dm_rdata,          32'h0);
    bus.dm_req = 1'b0;
    tick();
    check("to_err_c18",      {31'h0, bus.err},      32'h0);
    check("to_dm_ready_c18", {31'h0, bus.dm_ready}, 32'h0);

    // Reset in the second grant cycle; a late ack afterwards is ignored.
    tick();
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_0090;
    tick();
    check("r_mem_req_c1", {31'h0, bus.mem_req}, 32'h1);
    tick();
    rst        = 1'b1;
    bus.dm_req = 1'b0;
    tick();
    check("r_mem_req_c3",  {31'h0, bus.mem_req},  32'h0);
    check("r_mem_addr_c3", bus.mem_addr,          32'h0);
    check("r_dm_ready_c3", {31'h0, bus.dm_ready}, 32'h0);
    check("r_err_c3",      {31'h0, bus.err},      32'h0);
    check("r_im_rdata_c3", bus.im_rdata,          32'h0);
    rst           = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0099;
    tick();
    check("r_dm_ready_c4", {31'h0, bus.dm_ready}, 32'h0);
    check("r_dm_rdata_c4", bus.dm_rdata,          32'h0);
    check("r_mem_req_c4",  {31'h0, bus.mem_req},  32'h0);
    bus.mem_ack = 1'b0;

    // Tie after a DM-only grant: fixed priority re-grants DM, round robin grants IM.
    tick();
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_00A0;
    tick();
    check("t_mem_addr_c1", bus.mem_addr, 32'h0000_00A0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0001;
    tick();
    check("t_dm_ready_c2", {31'h0, bus.dm_ready}, 32'h1);
    bus.mem_ack = 1'b0;
    bus.dm_req  = 1'b0;
    tick();
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_00A4;
    bus.im_req  = 1'b1;
    bus.im_addr = 32'h0000_00B0;
    tick();
    check("t_mem_req_c4", {31'h0, bus.mem_req}, 32'h1);
`ifdef ROUND_ROBIN_EN
    check("t_first_addr_c4", bus.mem_addr, 32'h0000_00B0);
`else
    check("t_first_addr_c4", bus.mem_addr, 32'h0000_00A4);
`endif
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0002;
    tick();
`ifdef ROUND_ROBIN_EN
    check("t_im_ready_c5", {31'h0, bus.im_ready}, 32'h1);
    bus.im_req = 1'b0;
`else
    check("t_dm_ready_c5", {31'h0, bus.dm_ready}, 32'h1);
    bus.dm_req = 1'b0;
`endif
    bus.mem_ack = 1'b0;
    tick();
`ifdef ROUND_ROBIN_EN
    check("t_second_addr_c6", bus.mem_addr, 32'h0000_00A4);
`else
    check("t_second_addr_c6", bus.mem_addr, 32'h0000_00B0);
`endif
    check("t_mem_req_c6", {31'h0, bus.mem_req}, 32'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0003;
    tick();
`ifdef ROUND_ROBIN_EN
    check("t_dm_ready_c7", {31'h0, bus.dm_ready}, 32'h1);
    check("t_dm_rdata_c7", bus.dm_rdata,          32'h0000_0003);
`else
    check("t_im_ready_c7", {31'h0, bus.im_ready}, 32'h1);
    check("t_im_rdata_c7", bus.im_rdata,          32'h0000_0003);
`endif
    bus.mem_ack = 1'b0;
    bus.im_req  = 1'b0;
    bus.dm_req  = 1'b0;
    tick();
    check("t_mem_req_c8", {31'h0, bus.mem_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
